// File: rtl/mont_exponentiation.sv
// 512-bit modular exponentiation x^e mod m using radix-2 interleaved Montgomery
// multiplication (R = 2^512). A bypass mode returns the single product x*R mod m.
module mont_exponentiation (
  input  logic         clk,
  input  logic         resetn,
  input  logic         startExponentiation,
  input  logic         multiplication_enable,
  input  logic [511:0] x,
  input  logic [511:0] exponent,
  input  logic [511:0] modulus,
  input  logic [511:0] Rmodm,
  input  logic [511:0] Rsquaredmodm,
  output logic         done,
  output logic [511:0] A_result
);

  typedef enum logic [2:0] {IDLE, LOAD, TOMONT, SQUARE, MULT, FROMMONT, DONE} state_t;

  localparam logic [9:0] MM_LAST = 10'd513;

  state_t       state_q;
  logic         mode_q;
  logic [511:0] x_q, e_q, m_q, rm_q, r2_q;
  logic [511:0] a_q, xt_q;
  logic [511:0] mma_q, mmb_q;
  logic [513:0] t_q;
  logic [9:0]   cnt_q;
  logic [9:0]   idx_q;
  logic         done_q;
  logic [511:0] res_q;

  logic [9:0]   t_d;
  logic [9:0]   idx_m1;
  logic [513:0] sum, sum2, t_d_step;
  logic [511:0] mm_res;
  logic [511:0] opa, opb;

  assign done     = done_q;
  assign A_result = res_q;
  assign idx_m1   = idx_q - 10'd1;

  // t = position of the highest set exponent bit plus one (0 for a zero exponent)
  always_comb begin
    t_d = '0;
    for (int i = 0; i < 512; i++)
      if (e_q[i]) t_d = 10'(i + 1);
  end

  // One Montgomery iteration and the closing conditional subtraction
  always_comb begin
    sum      = t_q + (mma_q[0] ? {2'b00, mmb_q} : 514'd0);
    sum2     = sum[0] ? sum + {2'b00, m_q} : sum;
    t_d_step = sum2 >> 1;
    mm_res   = (t_q >= {2'b00, m_q}) ? 512'(t_q - {2'b00, m_q}) : t_q[511:0];
  end

  always_comb begin
    opa = a_q;
    opb = a_q;
    case (state_q)
      TOMONT:   begin opa = x_q; opb = r2_q;   end
      MULT:     begin opa = a_q; opb = xt_q;   end
      FROMMONT: begin opa = a_q; opb = 512'd1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      rm_q    <= '0;
      r2_q    <= '0;
      a_q     <= '0;
      xt_q    <= '0;
      mma_q   <= '0;
      mmb_q   <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (startExponentiation) begin
          x_q     <= x;
          e_q     <= exponent;
          m_q     <= modulus;
          rm_q    <= Rmodm;
          r2_q    <= Rsquaredmodm;
          mode_q  <= multiplication_enable;
          state_q <= LOAD;
        end
        LOAD: begin
          a_q     <= rm_q;
          idx_q   <= t_d;
          cnt_q   <= '0;
          state_q <= TOMONT;
        end
        TOMONT, SQUARE, MULT, FROMMONT: begin
          if (cnt_q == 10'd0) begin
            mma_q <= opa;
            mmb_q <= opb;
            t_q   <= '0;
            cnt_q <= 10'd1;
          end else if (cnt_q != MM_LAST) begin
            t_q   <= t_d_step;
            mma_q <= mma_q >> 1;
            cnt_q <= cnt_q + 10'd1;
          end else begin
            cnt_q <= '0;
            case (state_q)
              TOMONT: if (mode_q) begin
                a_q     <= mm_res;
                state_q <= DONE;
              end else begin
                xt_q    <= mm_res;
                state_q <= (idx_q == 10'd0) ? FROMMONT : SQUARE;
              end
              SQUARE: begin
                a_q <= mm_res;
                if (e_q[idx_m1[8:0]]) state_q <= MULT;
                else begin
                  idx_q   <= idx_m1;
                  state_q <= (idx_q == 10'd1) ? FROMMONT : SQUARE;
                end
              end
              MULT: begin
                a_q     <= mm_res;
                idx_q   <= idx_m1;
                state_q <= (idx_q == 10'd1) ? FROMMONT : SQUARE;
              end
              default: begin
                a_q     <= mm_res;
                state_q <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          // Publish once on entry; leave only after done has been seen and start drops
          if (!done_q) begin
            done_q <= 1'b1;
            res_q  <= a_q;
          end else if (!startExponentiation) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exponentiation.sv
// Directed bench for mont_exponentiation: small hand-checked vectors mod 13,
// a 512-bit vector against a plain square-and-multiply model, and control corners.
module tb_mont_exponentiation;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         startExponentiation = 1'b0;
  logic         multiplication_enable = 1'b0;
  logic [511:0] x = '0, exponent = '0, modulus = '0, Rmodm = '0, Rsquaredmodm = '0;
  logic         done;
  logic [511:0] A_result;

  int nasserts = 0;
  int nfail = 0;

  mont_exponentiation dut (
    .clk(clk), .resetn(resetn), .startExponentiation(startExponentiation),
    .multiplication_enable(multiplication_enable), .x(x), .exponent(exponent),
    .modulus(modulus), .Rmodm(Rmodm), .Rsquaredmodm(Rsquaredmodm),
    .done(done), .A_result(A_result)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] M13 = 512'd13, RM13 = 512'd9, R2M13 = 512'd3;

  function automatic logic [511:0] modexp(input logic [511:0] b, input logic [511:0] e,
                                          input logic [511:0] m);
    logic [1023:0] r, bb, mm;
    mm = {512'd0, m};
    bb = {512'd0, b} % mm;
    r  = 1024'd1 % mm;
    for (int i = 511; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[511:0];
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives operands before an edge; that edge (E0) samples start
  task automatic start_op(input logic mode, input logic [511:0] xi, input logic [511:0] ei,
                          input logic [511:0] mi, input logic [511:0] rmi,
                          input logic [511:0] r2i, input logic keep);
    @(negedge clk);
    multiplication_enable = mode;
    x = xi; exponent = ei; modulus = mi; Rmodm = rmi; Rsquaredmodm = r2i;
    startExponentiation = 1'b1;
    @(posedge clk);
    #2;
    if (!keep) startExponentiation = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [511:0] exp_res);
    int n;
    n = 0;
    while (n < exp_lat + 50) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
    chk({tag, "_latency"}, 512'(n), 512'(exp_lat));
    chk({tag, "_result"}, A_result, exp_res);
  endtask

  task automatic leave_done(input string tag, input logic [511:0] exp_res);
    @(posedge clk);
    #1;
    chk({tag, "_idle_done"}, {511'd0, done}, 512'd0);
    chk({tag, "_idle_hold"}, A_result, exp_res);
  endtask

  initial begin
    logic [511:0] bm, bx, brm, br2, bexp;
    logic [1024:0] rr;
    logic         held_ok;

    #23;
    chk("reset_done", {511'd0, done}, 512'd0);
    chk("reset_result", A_result, 512'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 2^5 mod 13 = 6; 7 montmuls
    start_op(1'b0, 512'd2, 512'd5, M13, RM13, R2M13, 1'b0);
    wait_done("x2e5", 2 + 514 * 7, 512'd6);
    leave_done("x2e5", 512'd6);

    start_op(1'b0, 512'd7, 512'd1, M13, RM13, R2M13, 1'b0);
    wait_done("x7e1", 2 + 514 * 4, 512'd7);
    leave_done("x7e1", 512'd7);

    start_op(1'b0, 512'd5, 512'd0, M13, RM13, R2M13, 1'b0);
    wait_done("x5e0", 2 + 514 * 2, 512'd1);
    leave_done("x5e0", 512'd1);

    // product mode: 2 * 2^512 mod 13 = 2*9 mod 13 = 5; exponent ignored
    start_op(1'b1, 512'd2, 512'd5, M13, RM13, R2M13, 1'b0);
    wait_done("prod", 516, 512'd5);
    leave_done("prod", 512'd5);

    // 512-bit vector, exponent 0xb7: t=8, w=6
    bm   = {16{32'hf21ecbae}} | 512'd1;
    bx   = {16{32'hd5361227}};
    brm  = 512'd0 - bm;
    rr   = (1025'd1 << 1024) % {513'd0, bm};
    br2  = rr[511:0];
    bexp = modexp(bx, 512'hb7, bm);
    start_op(1'b0, bx, 512'hb7, bm, brm, br2, 1'b0);
    wait_done("wide", 2 + 514 * 16, bexp);
    leave_done("wide", bexp);

    // start held high after done: no restart, outputs stable
    start_op(1'b0, 512'd2, 512'd5, M13, RM13, R2M13, 1'b1);
    wait_done("held", 2 + 514 * 7, 512'd6);
    held_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || A_result !== 512'd6) held_ok = 1'b0;
    end
    chk("held_done", {511'd0, done}, 512'd1);
    chk("held_stable", {511'd0, held_ok}, 512'd1);
    @(negedge clk);
    startExponentiation = 1'b0;
    leave_done("held", 512'd6);
    start_op(1'b0, 512'd7, 512'd1, M13, RM13, R2M13, 1'b0);
    wait_done("rerun", 2 + 514 * 4, 512'd7);
    leave_done("rerun", 512'd7);

    // asynchronous reset in the middle of the first SQUARE
    start_op(1'b0, 512'd2, 512'd5, M13, RM13, R2M13, 1'b0);
    repeat (600) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("midreset_done", {511'd0, done}, 512'd0);
    chk("midreset_result", A_result, 512'd0);
    @(negedge clk);
    resetn = 1'b1;
    // 3^4 mod 13 = 81 mod 13 = 3; t=3, w=1
    start_op(1'b0, 512'd3, 512'd4, M13, RM13, R2M13, 1'b0);
    wait_done("postreset", 2 + 514 * 6, 512'd3);
    leave_done("postreset", 512'd3);

    // inputs scrambled right after sampling must not matter
    start_op(1'b0, 512'd2, 512'd5, M13, RM13, R2M13, 1'b0);
    multiplication_enable = 1'b1;
    x = 512'd11; exponent = 512'h1234; modulus = 512'd17;
    Rmodm = 512'd4; Rsquaredmodm = 512'd16;
    wait_done("latched", 2 + 514 * 7, 512'd6);
    leave_done("latched", 512'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
